// File: rtl/maze_pkg.sv
// Shared definitions for the keypad-to-maze command path.
// Holds the command codes, the keypad codes that map to commands,
// the command generator FSM state type, the synchronised sample
// layout and the key-to-command lookup.
package maze_pkg;

    localparam int unsigned CMD_W    = 3;
    localparam int unsigned KEY_W    = 4;
    localparam int unsigned SAMPLE_W = KEY_W + 1;

    typedef logic [CMD_W-1:0] cmd_t;

    localparam cmd_t CMD_NONE    = 3'd0;
    localparam cmd_t CMD_UP      = 3'd1;
    localparam cmd_t CMD_DOWN    = 3'd2;
    localparam cmd_t CMD_LEFT    = 3'd3;
    localparam cmd_t CMD_RIGHT   = 3'd4;
    localparam cmd_t CMD_CONFIRM = 3'd5;
    localparam cmd_t CMD_RESTART = 3'd6;

    localparam logic [KEY_W-1:0] KEY_UP      = 4'd1;
    localparam logic [KEY_W-1:0] KEY_DOWN    = 4'd9;
    localparam logic [KEY_W-1:0] KEY_LEFT    = 4'd4;
    localparam logic [KEY_W-1:0] KEY_RIGHT   = 4'd6;
    localparam logic [KEY_W-1:0] KEY_CONFIRM = 4'd5;
    localparam logic [KEY_W-1:0] KEY_RESTART = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_DELAY,
        ST_REPEAT,
        ST_HOLD
    } kcg_state_t;

    // Synchronised scanner sample: press level on top, key code below.
    typedef struct packed {
        logic             flag;
        logic [KEY_W-1:0] value;
    } key_sample_t;

    // Keypad code to maze command; unmapped keys give CMD_NONE.
    function automatic cmd_t key_to_cmd(input logic [KEY_W-1:0] key);
        cmd_t c;
        case (key)
            KEY_UP:      c = CMD_UP;
            KEY_DOWN:    c = CMD_DOWN;
            KEY_LEFT:    c = CMD_LEFT;
            KEY_RIGHT:   c = CMD_RIGHT;
            KEY_CONFIRM: c = CMD_CONFIRM;
            KEY_RESTART: c = CMD_RESTART;
            default:     c = CMD_NONE;
        endcase
        return c;
    endfunction

    // Direction commands are the only ones that auto-repeat.
    function automatic logic is_direction(input cmd_t c);
        return (c >= CMD_UP) && (c <= CMD_RIGHT);
    endfunction

endpackage

// File: rtl/key_stable_filter.sv
// Stability filter for the synchronised keypad sample.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   sample          synchronised {flag, value} sample
//   stable_c        sample has been unchanged for N cycles (combinational)
//   value_c         current sample when stable, otherwise the last stable one
module key_stable_filter #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned N     = 1000000,
    parameter int unsigned CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    output logic             stable_c,
    output logic [WIDTH-1:0] value_c
);

    localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             diff_c;

    // Count is the updated value so that a sample is stable in its N-th cycle.
    always_comb begin
        diff_c = (sample != prev_q);
        if (diff_c) begin
            cnt_d = '0;
        end else if (cnt_q == N_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        stable_c = !diff_c && (cnt_d == N_C);
        value_c  = stable_c ? sample : last_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= '0;
            last_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= sample;
            cnt_q  <= cnt_d;
            if (stable_c) begin
                last_q <= sample;
            end
        end
    end

endmodule

// File: rtl/key_cmd_gen.sv
// Keypad press to maze command generator.
// Synchronises and debounces the scanner outputs, turns each clean press
// into a command (auto-repeating direction keys while held) and hands
// commands to the game FSM through a one-deep valid/ready register.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   key_value    scanner key code (asynchronous)
//   key_flag     scanner press level (asynchronous)
//   cmd_ready    consumer accepts cmd this cycle
//   cmd_valid    command pending
//   cmd          command code
//   key_held     debounced key-down level
//   cmd_drop     one-cycle pulse when an event is lost to a full register
module key_cmd_gen
    import maze_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_value,
    input  logic             key_flag,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd,
    output logic             key_held,
    output logic             cmd_drop
);

    localparam logic [CNT_W-1:0] DELAY_C    = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_C   = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] TIMER_MAX  = {CNT_W{1'b1}};

    key_sample_t          sync1_q;
    key_sample_t          sync2_q;
    logic                 stable_c;
    logic [SAMPLE_W-1:0]  stable_vec_c;
    key_sample_t          stable_s;

    kcg_state_t           state_q;
    kcg_state_t           state_d;
    logic [CNT_W-1:0]     timer_q;
    logic [CNT_W-1:0]     timer_d;
    logic [CNT_W-1:0]     timer_inc_c;
    logic [KEY_W-1:0]     key_q;
    logic [KEY_W-1:0]     key_d;
    logic                 event_c;
    cmd_t                 event_cmd_c;
    cmd_t                 press_cmd_c;
    cmd_t                 held_cmd_c;
    logic                 active_c;

    // Two-flop synchroniser for the asynchronous scanner outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_sample_t'({key_flag, key_value});
            sync2_q <= sync1_q;
        end
    end

    key_stable_filter #(
        .WIDTH (SAMPLE_W),
        .N     (DEBOUNCE_CYCLES),
        .CNT_W (CNT_W)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .sample   (sync2_q),
        .stable_c (stable_c),
        .value_c  (stable_vec_c)
    );

    assign stable_s    = key_sample_t'(stable_vec_c);
    assign press_cmd_c = key_to_cmd(stable_s.value);
    assign held_cmd_c  = key_to_cmd(key_q);
    assign timer_inc_c = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);
    assign active_c    = (state_q == ST_DELAY) || (state_q == ST_REPEAT) || (state_q == ST_HOLD);

    // Next-state, timer and event generation.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        key_d       = key_q;
        event_c     = 1'b0;
        event_cmd_c = CMD_NONE;

        case (state_q)
            ST_IDLE: begin
                if (stable_c && stable_s.flag) begin
                    state_d     = ST_PRESS;
                    key_d       = stable_s.value;
                    timer_d     = '0;
                    event_c     = (press_cmd_c != CMD_NONE);
                    event_cmd_c = press_cmd_c;
                end
            end
            // Timer is zero here; counting the press cycle keeps the first
            // repeat exactly REPEAT_DELAY cycles after the press event.
            ST_PRESS: begin
                timer_d = timer_inc_c;
                state_d = is_direction(held_cmd_c) ? ST_DELAY : ST_HOLD;
            end
            ST_DELAY: begin
                timer_d = timer_inc_c;
                if (timer_inc_c == DELAY_C) begin
                    event_c     = 1'b1;
                    event_cmd_c = held_cmd_c;
                    timer_d     = '0;
                    state_d     = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                timer_d = timer_inc_c;
                if (timer_inc_c == PERIOD_C) begin
                    event_c     = 1'b1;
                    event_cmd_c = held_cmd_c;
                    timer_d     = '0;
                end
            end
            ST_HOLD: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clean release or a clean key change overrides any repeat due now.
        if (active_c && stable_c) begin
            if (!stable_s.flag) begin
                state_d     = ST_IDLE;
                timer_d     = '0;
                event_c     = 1'b0;
                event_cmd_c = CMD_NONE;
            end else if (stable_s.value != key_q) begin
                state_d     = ST_PRESS;
                key_d       = stable_s.value;
                timer_d     = '0;
                event_c     = (press_cmd_c != CMD_NONE);
                event_cmd_c = press_cmd_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            key_q   <= key_d;
        end
    end

    // One-deep holding register; an event may reload it in the accept cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NONE;
            key_held  <= 1'b0;
            cmd_drop  <= 1'b0;
        end else begin
            key_held <= (state_d != ST_IDLE);
            cmd_drop <= 1'b0;
            if (event_c) begin
                if (!cmd_valid || cmd_ready) begin
                    cmd_valid <= 1'b1;
                    cmd       <= event_cmd_c;
                end else begin
                    cmd_drop <= 1'b1;
                end
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_cmd_gen.sv
// Bench for key_cmd_gen: press-table vectors, hand sequences for glitch,
// back-pressure and reset corners, and randomized traffic compared every
// cycle against a behavioural model.
module tb_key_cmd_gen;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_value;
    logic       key_flag;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       key_held;
    logic       cmd_drop;

    int total = 0;
    int bad   = 0;

    key_cmd_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (25)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_value (key_value),
        .key_flag  (key_flag),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .key_held  (key_held),
        .cmd_drop  (cmd_drop)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [4:0] m_p1, m_p2;
    int         m_age;
    logic       m_held;
    logic [3:0] m_key;
    int         m_t;
    logic       m_valid;
    logic [2:0] m_cmd;
    logic       m_drop;

    function automatic int map_key(input int k);
        case (k)
            1:  return 1;
            9:  return 2;
            4:  return 3;
            6:  return 4;
            5:  return 5;
            15: return 6;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the model, evaluated with the inputs the DUT just sampled.
    task automatic model_step();
        logic       stable;
        logic       ev;
        int         evc;
        logic [4:0] nxt;
        if (!reset) begin
            m_p1 = '0; m_p2 = '0; m_age = 0; m_held = 0; m_key = '0; m_t = 0;
            m_valid = 0; m_cmd = '0; m_drop = 0;
            return;
        end
        stable = (m_age >= DEB);
        ev  = 0;
        evc = 0;
        if (!m_held) begin
            if (stable && m_p2[4]) begin
                m_held = 1; m_key = m_p2[3:0]; m_t = 1;
                evc = map_key(int'(m_p2[3:0])); ev = (evc != 0);
            end
        end else if (stable && !m_p2[4]) begin
            m_held = 0;
        end else if (stable && m_p2[3:0] != m_key) begin
            m_key = m_p2[3:0]; m_t = 1;
            evc = map_key(int'(m_p2[3:0])); ev = (evc != 0);
        end else begin
            evc = map_key(int'(m_key));
            if (evc >= 1 && evc <= 4 && (m_t == RD || (m_t > RD && (m_t - RD) % RP == 0)))
                ev = 1;
            m_t++;
        end
        m_drop = 0;
        if (ev) begin
            if (!m_valid || cmd_ready) begin
                m_valid = 1; m_cmd = 3'(evc);
            end else begin
                m_drop = 1;
            end
        end else if (m_valid && cmd_ready) begin
            m_valid = 0;
        end
        nxt   = m_p1;
        m_age = (nxt == m_p2) ? m_age + 1 : 0;
        m_p2  = nxt;
        m_p1  = {key_flag, key_value};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("mdl_valid", int'(cmd_valid), int'(m_valid));
        check("mdl_cmd",   int'(cmd),       int'(m_cmd));
        check("mdl_held",  int'(key_held),  int'(m_held));
        check("mdl_drop",  int'(cmd_drop),  int'(m_drop));
    endtask

    typedef struct {
        logic [3:0] key;
        int         hold;
        int         exp_n;
        int         exp_cmd;
    } vec_t;

    vec_t vecs[9];
    int   first_v, first_h, n_v, cmd_bad, drops;
    logic held_seen, valid_seen;

    initial begin
        // key, cycles held at the pins, commands expected, command code
        vecs[0] = '{4'd1,  10, 1, 1};
        vecs[1] = '{4'd6,  60, 6, 4};
        vecs[2] = '{4'd5,  60, 1, 5};
        vecs[3] = '{4'd12, 20, 0, 0};
        vecs[4] = '{4'd9,  34, 3, 2};
        vecs[5] = '{4'd4,  20, 1, 3};
        vecs[6] = '{4'd4,  21, 2, 3};
        vecs[7] = '{4'd15, 30, 1, 6};
        vecs[8] = '{4'd0,  15, 0, 0};

        reset = 0; key_flag = 0; key_value = 0; cmd_ready = 1;
        repeat (3) tick();
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_cmd",   int'(cmd),       0);
        check("rst_held",  int'(key_held),  0);
        check("rst_drop",  int'(cmd_drop),  0);
        reset = 1;
        repeat (10) tick();

        // Press table with the consumer always ready.
        for (int v = 0; v < 9; v++) begin
            first_v = -1; first_h = -1; n_v = 0; cmd_bad = 0;
            key_value = vecs[v].key; key_flag = 1;
            for (int i = 1; i <= vecs[v].hold + 25; i++) begin
                tick();
                if (i == vecs[v].hold) key_flag = 0;
                if (cmd_valid) begin
                    n_v++;
                    if (first_v < 0) first_v = i;
                    if (int'(cmd) != vecs[v].exp_cmd) cmd_bad++;
                end
                if (key_held && first_h < 0) first_h = i;
            end
            check($sformatf("vec%0d_count", v), n_v, vecs[v].exp_n);
            if (vecs[v].exp_n > 0) begin
                check($sformatf("vec%0d_latency", v), first_v, 7);
                check($sformatf("vec%0d_badcmd", v), cmd_bad, 0);
            end
            check($sformatf("vec%0d_held_rise", v), first_h, 7);
            check($sformatf("vec%0d_held_end", v), int'(key_held), 0);
        end

        // Flag glitches of 3 cycles never qualify.
        key_value = 4'd1; key_flag = 0;
        repeat (10) tick();
        valid_seen = 0; held_seen = 0;
        for (int p = 0; p < 10; p++) begin
            key_flag = 1;
            repeat (3) begin tick(); valid_seen |= cmd_valid; held_seen |= key_held; end
            key_flag = 0;
            repeat (3) begin tick(); valid_seen |= cmd_valid; held_seen |= key_held; end
        end
        repeat (20) begin tick(); valid_seen |= cmd_valid; held_seen |= key_held; end
        check("glitch_valid", int'(valid_seen), 0);
        check("glitch_held",  int'(held_seen),  0);

        // Back-pressure: second press is dropped, pending cmd unchanged.
        cmd_ready = 0; drops = 0; cmd_bad = 0;
        key_value = 4'd1; key_flag = 1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 11) key_flag = 0;
            if (i == 21) begin key_value = 4'd9; key_flag = 1; end
            if (i == 31) key_flag = 0;
            tick();
            if (cmd_drop) drops++;
            if (i >= 7 && (!cmd_valid || cmd != 3'd1)) cmd_bad++;
        end
        check("bp_drops", drops, 1);
        check("bp_pending", cmd_bad, 0);
        cmd_ready = 1;
        tick();
        check("bp_release_valid", int'(cmd_valid), 0);
        repeat (5) tick();

        // Reset while repeating with a command pending.
        cmd_ready = 0; key_value = 4'd4; key_flag = 1;
        repeat (40) tick();
        check("pre_rst_valid", int'(cmd_valid), 1);
        reset = 0;
        tick();
        check("mid_rst_valid", int'(cmd_valid), 0);
        check("mid_rst_cmd",   int'(cmd),       0);
        check("mid_rst_held",  int'(key_held),  0);
        check("mid_rst_drop",  int'(cmd_drop),  0);
        reset = 1;
        first_v = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (cmd_valid && first_v < 0) begin
                first_v = i;
                check("post_rst_cmd", int'(cmd), 3);
            end
        end
        check("post_rst_latency", first_v, 7);
        cmd_ready = 1; key_flag = 0;
        repeat (15) tick();

        // Randomized traffic against the model.
        for (int s = 0; s < 90; s++) begin
            int len;
            len = $urandom_range(1, 40);
            key_flag  = ($urandom_range(0, 2) != 0);
            key_value = ($urandom_range(0, 1) != 0) ? 4'(map_dir_key($urandom_range(0, 3)))
                                                    : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) reset = 0;
            for (int j = 0; j < len; j++) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
                tick();
                reset = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int map_dir_key(input int i);
        case (i)
            0: return 1;
            1: return 9;
            2: return 4;
            default: return 6;
        endcase
    endfunction

endmodule
